// File: rtl/uart_char_rx.sv
// uart_char_rx
//
// Purpose:
//   Receives an asynchronous 8N1 serial line and recovers one ASCII byte per
//   frame. Each byte goes to a downstream keyword checker. A correctly framed
//   byte is presented on a held output together with a one-cycle valid strobe.
//   A frame whose stop bit reads 0 raises a one-cycle error strobe instead.
//
// Ports:
//   clk        - single clock; all state updates on the rising edge
//   reset      - asynchronous, active-low reset (0 = reset, 1 = run)
//   rxd        - serial line: idle high, LSB first, start 0, 8 data, stop 1
//   char       - last correctly framed byte, held until the next good frame
//   char_valid - one-cycle pulse in the cycle char is updated
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   busy       - high whenever the receiver FSM is not idle
//
// Parameter:
//   CLKS_PER_BIT - clock cycles per serial bit; must be even and >= 4

module uart_char_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] char,
  output logic       char_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      char_q, char_d;
  logic            char_valid_q, char_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic            rxd_meta_q, rxd_meta_d;
  logic            rxd_s_q, rxd_s_d;

  // Two-flop synchronizer. It resets to the idle line level so that reset
  // release cannot look like a start bit.
  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
    end
  end

  // Next-state logic. The bit-time counter free-runs and is cleared on every
  // state change and on every sample point. START checks the line at mid
  // start bit. After that point, every sample lands a full bit time later,
  // which is mid-bit. STOP ends at mid stop bit, so back-to-back frames
  // still have half a bit of margin before the next start edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    sh_d         = sh_q;
    char_d       = char_q;
    char_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          // A line that is high again at mid start bit was a glitch.
          state_d = rxd_s_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rxd_s_q, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            char_d       = sh_q;
            char_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d  = 1'b1;
            state_d      = BREAK;
          end
        end
      end

      // BREAK waits for the line to return high, so that a held-low line
      // does not generate a stream of false start bits.
      BREAK: begin
        cnt_d = '0;
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      sh_q         <= 8'h00;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign char       = char_q;
  assign char_valid = char_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
